// File: rtl/pattern_gen_pkg.sv
// Shared types and constants for the test pattern generator: sequencer states,
// pattern codes and a small parameter helper.
package pattern_gen_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACTIVE,
        HBLANK,
        HOLD,
        VBLANK
    } state_t;

    typedef logic [1:0] pat_code_t;

    localparam pat_code_t PAT_GRAY_BARS = 2'd0;
    localparam pat_code_t PAT_RAMP      = 2'd1;
    localparam pat_code_t PAT_CHECKER   = 2'd2;
    localparam pat_code_t PAT_SOLID     = 2'd3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/phase_counter.sv
// Loadable down-counter that times each sequencer phase; tc flags the last
// cycle of the loaded duration.
module phase_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/pattern_timing_ctrl.sv
// Frame/line timing sequencer: generates frame/line envelopes, pixel coordinates
// and a per-frame latched pattern code; always finishes a started frame.
module pattern_timing_ctrl
    import pattern_gen_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 160,
    parameter int V_ACTIVE = 480,
    parameter int V_BLANK  = 45,
    parameter int FV_SETUP = 8,
    parameter int FV_HOLD  = 8,
    parameter int XW       = 12,
    parameter int YW       = 11
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enable,
    input  logic [1:0]    pat_sel_in,
    output logic [1:0]    pat_sel,
    output logic          frame_valid,
    output logic          line_valid,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic          frame_start,
    output logic          frame_end,
    output logic [15:0]   frame_cnt,
    output logic          busy
);

    localparam int MAX_DUR = max_int(max_int(max_int(H_ACTIVE, H_BLANK), max_int(V_BLANK, FV_SETUP)),
                                     max_int(FV_HOLD, 1));
    localparam int CW      = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;

    state_t        state, next_state;
    logic          tc;
    logic          cnt_load;
    logic [CW-1:0] cnt_load_val;

    logic          frame_valid_d, line_valid_d, frame_start_d, frame_end_d, busy_d;
    logic [XW-1:0] pix_x_d;
    logic [YW-1:0] pix_y_d;
    logic [15:0]   frame_cnt_d;
    logic [1:0]    pat_sel_d;

    // Counter holds duration-1, so tc is high on the final cycle of a phase.
    function automatic logic [CW-1:0] phase_len(input state_t s);
        case (s)
            SETUP:   return CW'(FV_SETUP - 1);
            ACTIVE:  return CW'(H_ACTIVE - 1);
            HBLANK:  return CW'(H_BLANK - 1);
            HOLD:    return CW'(FV_HOLD - 1);
            VBLANK:  return CW'(V_BLANK - 1);
            default: return '0;
        endcase
    endfunction

    phase_counter #(.W(CW)) u_phase_counter (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .en       (state != IDLE),
        .load_val (cnt_load_val),
        .tc       (tc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (enable) next_state = SETUP;
            SETUP:   if (tc) next_state = ACTIVE;
            ACTIVE:  if (tc) next_state = (pix_y < YW'(V_ACTIVE - 1)) ? HBLANK : HOLD;
            HBLANK:  if (tc) next_state = ACTIVE;
            HOLD:    if (tc) next_state = VBLANK;
            VBLANK:  if (tc) next_state = enable ? SETUP : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are decoded from next_state and registered, so they align with
    // the state they describe.
    always_comb begin
        cnt_load      = (next_state != state);
        cnt_load_val  = phase_len(next_state);
        frame_valid_d = next_state inside {SETUP, ACTIVE, HBLANK, HOLD};
        line_valid_d  = (next_state == ACTIVE);
        pix_x_d       = '0;
        if ((next_state == ACTIVE) && (state == ACTIVE)) begin
            pix_x_d = pix_x + XW'(1);
        end
        pix_y_d = '0;
        if (frame_valid_d) begin
            pix_y_d = ((state == HBLANK) && (next_state == ACTIVE)) ? pix_y + YW'(1) : pix_y;
        end
        frame_start_d = (next_state == SETUP) && (state != SETUP);
        frame_end_d   = (state == HOLD) && (next_state == VBLANK);
        frame_cnt_d   = frame_end_d ? frame_cnt + 16'd1 : frame_cnt;
        pat_sel_d     = frame_start_d ? pat_sel_in : pat_sel;
        busy_d        = (next_state != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_valid <= 1'b0;
            line_valid  <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            frame_cnt   <= '0;
            pat_sel     <= '0;
            busy        <= 1'b0;
        end else begin
            frame_valid <= frame_valid_d;
            line_valid  <= line_valid_d;
            pix_x       <= pix_x_d;
            pix_y       <= pix_y_d;
            frame_start <= frame_start_d;
            frame_end   <= frame_end_d;
            frame_cnt   <= frame_cnt_d;
            pat_sel     <= pat_sel_d;
            busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_pattern_timing_ctrl.sv
// Directed bench for pattern_timing_ctrl using a tiny 4x3 frame and a 1x1 frame.
module tb_pattern_timing_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  pat_sel_in = 2'd0;
    logic [1:0]  pat_sel;
    logic        frame_valid, line_valid, frame_start, frame_end, busy;
    logic [11:0] pix_x;
    logic [10:0] pix_y;
    logic [15:0] frame_cnt;

    logic        enable1 = 1'b0;
    logic [1:0]  pat_sel1;
    logic        frame_valid1, line_valid1, frame_start1, frame_end1, busy1;
    logic [11:0] pix_x1;
    logic [10:0] pix_y1;
    logic [15:0] frame_cnt1;

    int tests_run = 0;
    int tests_failed = 0;

    // Hand-derived 20-cycle frame: SETUP, 3 lines of 4 with 2-cycle gaps, HOLD, 2 VBLANK.
    logic [0:19] exp_fv   = 20'b1111_1111_1111_1111_1100;
    logic [0:19] exp_lv   = 20'b0111_1001_1110_0111_1000;
    logic [0:19] exp_fs   = 20'b1000_0000_0000_0000_0000;
    logic [0:19] exp_fe   = 20'b0000_0000_0000_0000_0010;
    int          exp_x[20] = '{0,0,1,2,3,0,0,0,1,2,3,0,0,0,1,2,3,0,0,0};
    int          exp_y[20] = '{0,0,0,0,0,0,0,1,1,1,1,1,1,2,2,2,2,2,0,0};

    always #5 clk = ~clk;

    pattern_timing_ctrl #(
        .H_ACTIVE(4), .H_BLANK(2), .V_ACTIVE(3), .V_BLANK(2), .FV_SETUP(1), .FV_HOLD(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .pat_sel_in(pat_sel_in),
        .pat_sel(pat_sel), .frame_valid(frame_valid), .line_valid(line_valid),
        .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start), .frame_end(frame_end),
        .frame_cnt(frame_cnt), .busy(busy)
    );

    pattern_timing_ctrl #(
        .H_ACTIVE(1), .H_BLANK(2), .V_ACTIVE(1), .V_BLANK(2), .FV_SETUP(1), .FV_HOLD(1)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .enable(enable1), .pat_sel_in(2'd1),
        .pat_sel(pat_sel1), .frame_valid(frame_valid1), .line_valid(line_valid1),
        .pix_x(pix_x1), .pix_y(pix_y1), .frame_start(frame_start1), .frame_end(frame_end1),
        .frame_cnt(frame_cnt1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // {fv, lv, fs, fe, busy, pat_sel, frame_cnt, pix_x, pix_y}
    function automatic logic [63:0] pack_obs();
        return {18'd0, frame_valid, line_valid, frame_start, frame_end, busy,
                pat_sel, frame_cnt, pix_x, pix_y};
    endfunction

    function automatic logic [63:0] pack_exp(input logic fv, input logic lv, input logic fs,
                                             input logic fe, input logic bz, input logic [1:0] pat,
                                             input logic [15:0] cnt, input int x, input int y);
        return {18'd0, fv, lv, fs, fe, bz, pat, cnt, 12'(x), 11'(y)};
    endfunction

    // Entered at the sample point of the frame_start cycle; leaves one cycle after VBLANK.
    task automatic check_frame(input string name, input logic [15:0] cnt0, input logic [1:0] pat,
                               input int pat_chg_at, input int drop_at);
        logic [15:0] exp_cnt;
        for (int t = 0; t < 20; t++) begin
            exp_cnt = (t >= 18) ? cnt0 + 16'd1 : cnt0;
            check($sformatf("%s_t%0d", name, t), pack_obs(),
                  pack_exp(exp_fv[t], exp_lv[t], exp_fs[t], exp_fe[t], 1'b1, pat, exp_cnt,
                           exp_x[t], exp_y[t]));
            if (t == pat_chg_at) pat_sel_in = 2'd2;
            if (t == drop_at) enable = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        int fs_seen, busy_seen, fv1_n, lv1_n, fs1_n, fe1_n;

        #12;
        check("reset_outputs", pack_obs(), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_hold", pack_obs(), 64'd0);

        enable = 1'b1;
        @(negedge clk);
        check_frame("f1", 16'd0, 2'd0, 5, -1);
        check_frame("f2", 16'd1, 2'd2, -1, 8);
        check("f2_idle", pack_obs(), pack_exp(0, 0, 0, 0, 0, 2'd2, 16'd2, 0, 0));

        fs_seen = 0;
        busy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            fs_seen += int'(frame_start);
            busy_seen += int'(busy);
        end
        check("no_restart_fs", 64'(fs_seen), 64'd0);
        check("no_restart_busy", 64'(busy_seen), 64'd0);

        force dut.frame_cnt = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.frame_cnt;
        @(negedge clk);
        check("wrap_preset", 64'(frame_cnt), 64'hFFFF);
        enable = 1'b1;
        @(negedge clk);
        check_frame("wrap", 16'hFFFF, 2'd2, -1, 2);
        check("wrap_idle", pack_obs(), pack_exp(0, 0, 0, 0, 0, 2'd2, 16'd0, 0, 0));

        enable = 1'b1;
        pat_sel_in = 2'd3;
        repeat (4) @(negedge clk);
        check("pre_rst_active", 64'(line_valid), 64'd1);
        #2 reset_n = 1'b0;
        #1 check("async_rst", pack_obs(), 64'd0);
        @(negedge clk);
        check("rst_held", pack_obs(), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check_frame("rst", 16'd0, 2'd3, -1, 2);

        fv1_n = 0; lv1_n = 0; fs1_n = 0; fe1_n = 0;
        enable1 = 1'b1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (t == 0) enable1 = 1'b0;
            fv1_n += int'(frame_valid1);
            lv1_n += int'(line_valid1);
            fs1_n += int'(frame_start1);
            fe1_n += int'(frame_end1);
            if (t == 1) check("px1_line", {frame_valid1, line_valid1, pix_x1, pix_y1},
                              {1'b1, 1'b1, 12'd0, 11'd0});
        end
        check("px1_fv_cycles", 64'(fv1_n), 64'd3);
        check("px1_lv_cycles", 64'(lv1_n), 64'd1);
        check("px1_fs_count", 64'(fs1_n), 64'd1);
        check("px1_fe_count", 64'(fe1_n), 64'd1);
        check("px1_end", {busy1, pat_sel1, frame_cnt1}, {1'b0, 2'd1, 16'd1});

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pattern_timing_ctrl.md
# pattern_timing_ctrl

Frame/line timing sequencer for the on-chip test pattern generator. Runs from the oscillator clock and drives `frame_valid`/`line_valid` plus pixel coordinates for the grayscale/pattern datapath. Latches the pattern selection once per frame so the datapath never changes pattern mid-frame. Stops cleanly at a frame boundary when disabled, for example when standby is requested.

## Interface
- `H_ACTIVE`, 640, pixels per line (line_valid high cycles), ≥1
- `H_BLANK`, 160, inter-line blanking cycles inside a frame, ≥1
- `V_ACTIVE`, 480, lines per frame, ≥1
- `V_BLANK`, 45, cycles with frame_valid low between frames, ≥1
- `FV_SETUP`, 8, cycles from frame_valid rise to first line_valid, ≥1
- `FV_HOLD`, 8, cycles from last line_valid fall to frame_valid fall, ≥1
- `XW`, 12, pix_x width; `YW`, 11, pix_y width
- `clk`  in  1  pixel clock (133 MHz oscillator)
- `reset_n`  in  1  asynchronous, active-low reset
- `enable`  in  1  run request; level-sensitive
- `pat_sel_in`  in  2  requested pattern code
- `pat_sel`  out  2  pattern code latched for current frame
- `frame_valid`  out  1  frame envelope
- `line_valid`  out  1  active-pixel qualifier
- `pix_x`  out  XW  pixel index in line; 0 when line_valid=0
- `pix_y`  out  YW  line index in frame; 0 outside SETUP..HOLD
- `frame_start`  out  1  one-cycle pulse on first frame_valid cycle
- `frame_end`  out  1  one-cycle pulse on first cycle after frame_valid falls
- `frame_cnt`  out  16  completed-frame count, wraps 0xFFFF→0
- `busy`  out  1  high in every state except IDLE

## Operation
- All outputs registered. Reset value of every output is 0; the state resets to IDLE.
- IDLE: outputs low. If enable=1, go to SETUP. On that same edge, latch pat_sel←pat_sel_in and assert frame_start.
- SETUP: frame_valid=1, line_valid=0. Lasts FV_SETUP cycles, then goes to ACTIVE with pix_y=0.
- ACTIVE: line_valid=1 and pix_x counts 0..H_ACTIVE-1. At the end of the line:
  - if pix_y<V_ACTIVE-1, go to HBLANK;
  - otherwise go to HOLD.
- HBLANK: line_valid=0 and pix_x=0, lasting H_BLANK cycles. pix_y increments on entry to the next ACTIVE.
- HOLD: frame_valid=1, line_valid=0, lasting FV_HOLD cycles. Then frame_valid←0, frame_end pulses, frame_cnt increments, and the state goes to VBLANK.
- VBLANK: V_BLANK cycles. At the end:
  - if enable=1, go to SETUP (relatch pat_sel, pulse frame_start);
  - otherwise go to IDLE.
- enable deasserting mid-frame has no effect until the end of VBLANK; a started frame always completes.
- pat_sel_in changes mid-frame are ignored until the next frame_start.
- Pattern codes: 0 grayscale bars, 1 horizontal ramp, 2 checkerboard, 3 solid mid-gray.
- Reset asserted mid-frame returns to IDLE immediately with all outputs 0. The first frame after reset release follows the IDLE rules.

## Timing
- Latency from enable rising in IDLE to frame_valid high is 1 cycle.
- Frame period with continuous enable: FV_SETUP + V_ACTIVE·H_ACTIVE + (V_ACTIVE−1)·H_BLANK + FV_HOLD + V_BLANK cycles.
- Between the last HBLANK-free line and HOLD, line_valid falls and HOLD starts in the same cycle.
- frame_start and frame_end never coincide. frame_cnt updates on the same edge that raises frame_end.
- pix_x and pix_y are valid in the same cycle as line_valid. The downstream pixel datapath adds its own fixed latency.

## Structure
- Shared package `pattern_gen_pkg`: state enum (IDLE, SETUP, ACTIVE, HBLANK, HOLD, VBLANK) and pattern-code constants (PAT_GRAY_BARS, PAT_RAMP, PAT_CHECKER, PAT_SOLID).
- One sub-module, `phase_counter`: a loadable down-counter with a terminal-count flag. The FSM loads it with each state's duration minus 1. pix_x and pix_y are separate up-counters in the top module.
- The duration counter width is derived from the largest parameter (clog2).

## Test plan
All scenarios use H_ACTIVE=4, H_BLANK=2, V_ACTIVE=3, V_BLANK=2, FV_SETUP=1, FV_HOLD=1.
- Reset then enable=1 held: frame_start 1 cycle after enable; line_valid has three 4-cycle bursts with 2-cycle gaps; pix_x 0,1,2,3; pix_y 0,1,2; frame_end pulses and frame_cnt=1; next frame_start 20 cycles after the first.
- enable dropped during line 1: frame completes, frame_end pulses, VBLANK lasts 2 cycles, then IDLE with busy=0 and no further frame_start.
- pat_sel_in 0→2 mid-frame: pat_sel stays 0 until the next frame_start, then becomes 2 in the same cycle as that pulse.
- reset_n low during ACTIVE: all outputs 0 asynchronously. After release with enable=1, a full frame runs with pix_y starting at 0.
- frame_cnt preset near wrap by running 65536 frames (or forced in sim): 0xFFFF→0 on frame_end with no glitch on other outputs.
- Single-pixel corner case with H_ACTIVE=1, V_ACTIVE=1: one 1-cycle line_valid; frame_valid high for 3 cycles.
